// File: rtl/hazard_tracker.sv
// D-stage hazard unit: shadows the E/M/W writers, raises the load-use/branch stall
// and picks forwarding sources for the D comparator operands and the E ALU operands.
module hazard_tracker #(
    parameter int REG_W = 5,
    parameter int T_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [T_W-1:0]   rs_Tuse,
    input  logic [T_W-1:0]   rt_Tuse,
    input  logic             we_D,
    input  logic [REG_W-1:0] dst_D,
    input  logic [T_W-1:0]   tnew_D,
    output logic             stall,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E
);
    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] dst;
        logic [T_W-1:0]   tnew;
    } stage_t;

    stage_t           e_q, m_q, w_q;
    logic [REG_W-1:0] rs_E, rt_E;

    logic wr_e, wr_m, wr_w;
    assign wr_e = e_q.we && (e_q.dst != '0);
    assign wr_m = m_q.we && (m_q.dst != '0);
    assign wr_w = w_q.we && (w_q.dst != '0);

    // Operand index 0 = rs, 1 = rt.
    logic [1:0][REG_W-1:0] src_d, src_e;
    logic [1:0][T_W-1:0]   tuse;
    logic [1:0][1:0]       fwd_d, fwd_e;
    logic [1:0]            stall_v;

    assign src_d = {rt_D, rs_D};
    assign src_e = {rt_E, rs_E};
    assign tuse  = {rt_Tuse, rs_Tuse};

    for (genvar g = 0; g < 2; g++) begin : g_opnd
        logic he_d, hm_d, hw_d, hm_e, hw_e, used;
        assign he_d = wr_e && (e_q.dst == src_d[g]);
        assign hm_d = wr_m && (m_q.dst == src_d[g]);
        assign hw_d = wr_w && (w_q.dst == src_d[g]);
        assign hm_e = wr_m && (m_q.dst == src_e[g]);
        assign hw_e = wr_w && (w_q.dst == src_e[g]);
        assign used = (tuse[g] != '1) && (src_d[g] != '0);

        assign stall_v[g] = used && ((he_d && (e_q.tnew > tuse[g])) ||
                                     (hm_d && (m_q.tnew > tuse[g])));

        // A younger match that is not ready yet masks any older match (returns 00).
        assign fwd_d[g] = he_d ? ((e_q.tnew == '0) ? 2'b01 : 2'b00) :
                          hm_d ? ((m_q.tnew == '0) ? 2'b10 : 2'b00) :
                          hw_d ? 2'b11 : 2'b00;
        assign fwd_e[g] = hm_e ? ((m_q.tnew == '0) ? 2'b01 : 2'b00) :
                          hw_e ? 2'b10 : 2'b00;
    end

    assign stall    = |stall_v;
    assign fwd_rs_D = fwd_d[0];
    assign fwd_rt_D = fwd_d[1];
    assign fwd_rs_E = fwd_e[0];
    assign fwd_rt_E = fwd_e[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q  <= '0;
            m_q  <= '0;
            w_q  <= '0;
            rs_E <= '0;
            rt_E <= '0;
        end else begin
            w_q.we   <= m_q.we;
            w_q.dst  <= m_q.dst;
            w_q.tnew <= '0;
            m_q.we   <= e_q.we;
            m_q.dst  <= e_q.dst;
            m_q.tnew <= (e_q.tnew == '0) ? '0 : e_q.tnew - T_W'(1);
            if (stall) begin
                e_q  <= '0;
                rs_E <= '0;
                rt_E <= '0;
            end else begin
                e_q.we   <= we_D;
                e_q.dst  <= dst_D;
                e_q.tnew <= tnew_D;
                rs_E     <= rs_D;
                rt_E     <= rt_D;
            end
        end
    end
endmodule

// File: tb/tb_hazard_tracker.sv
// Per-cycle vector table for hazard_tracker; expected {stall, fwd_rs_D, fwd_rt_D,
// fwd_rs_E, fwd_rt_E} go through a scoreboard queue and are compared at negedge.
module tb_hazard_tracker;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, dst_D;
    logic [1:0] rs_Tuse, rt_Tuse, tnew_D;
    logic       we_D;
    logic       stall;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

    hazard_tracker #(.REG_W(5), .T_W(2)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_Tuse(rs_Tuse), .rt_Tuse(rt_Tuse),
        .we_D(we_D), .dst_D(dst_D), .tnew_D(tnew_D),
        .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] rsu, rtu;
        logic       we;
        logic [4:0] dst;
        logic [1:0] tn;
        logic [8:0] ex;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] sb[$];
    int         errors = 0;
    int         checks = 0;
    wire  [8:0] got = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E};

    function automatic vec_t v(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] rsu, input logic [1:0] rtu,
                               input logic we, input logic [4:0] dst,
                               input logic [1:0] tn, input logic [8:0] ex);
        vec_t t;
        t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu;
        t.we = we; t.dst = dst; t.tn = tn; t.ex = ex;
        return t;
    endfunction

    function automatic vec_t nop(input logic [8:0] ex);
        return v(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, ex);
    endfunction

    function automatic vec_t wr(input logic [4:0] dst, input logic [1:0] tn);
        return v(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, dst, tn, 9'd0);
    endfunction

    task automatic drive(input vec_t t);
        rs_D = t.rs; rt_D = t.rt; rs_Tuse = t.rsu; rt_Tuse = t.rtu;
        we_D = t.we; dst_D = t.dst; tnew_D = t.tn;
        sb.push_back(t.ex);
    endtask

    task automatic check(input string nm, input int idx);
        logic [8:0] ex;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s[%0d]: scoreboard empty, got %b", nm, idx, got);
        end else begin
            ex = sb.pop_front();
            if (got !== ex) begin
                errors++;
                $display("FAIL %s[%0d]: got stall=%b fwd rsD=%b rtD=%b rsE=%b rtE=%b, expected stall=%b fwd rsD=%b rtD=%b rsE=%b rtE=%b",
                         nm, idx, got[8], got[7:6], got[5:4], got[3:2], got[1:0],
                         ex[8], ex[7:6], ex[5:4], ex[3:2], ex[1:0]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // load-use
        tbl.push_back(nop(9'd0));
        tbl.push_back(wr(5'd8, 2'd2));
        tbl.push_back(v(5'd8, 5'd0, 2'd1, 2'd1, 1'b1, 5'd10, 2'd1, 9'b1_00_00_00_00));
        tbl.push_back(v(5'd8, 5'd0, 2'd1, 2'd1, 1'b1, 5'd10, 2'd1, 9'b0_00_00_00_00));
        tbl.push_back(nop(9'b0_00_00_10_00));
        // branch after ALU
        tbl.push_back(wr(5'd9, 2'd1));
        tbl.push_back(v(5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 9'b1_00_00_00_00));
        tbl.push_back(v(5'd0, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 9'b0_00_10_00_00));
        tbl.push_back(nop(9'b0_00_00_00_10));
        // jal then jr
        tbl.push_back(wr(5'd31, 2'd0));
        tbl.push_back(v(5'd31, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 9'b0_01_00_00_00));
        tbl.push_back(nop(9'b0_00_00_01_00));
        // $0 writer/reader, unused operand
        tbl.push_back(wr(5'd0, 2'd2));
        tbl.push_back(v(5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 9'd0));
        tbl.push_back(wr(5'd5, 2'd2));
        tbl.push_back(v(5'd0, 5'd5, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 9'd0));
        tbl.push_back(nop(9'd0));
        tbl.push_back(nop(9'd0));
        // priority, Tuse=0 reader: stalls through E and M, then takes W
        tbl.push_back(wr(5'd4, 2'd1));
        tbl.push_back(wr(5'd4, 2'd2));
        tbl.push_back(v(5'd4, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 9'b1_00_00_00_00));
        tbl.push_back(v(5'd4, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 9'b1_00_00_00_00));
        tbl.push_back(v(5'd4, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 9'b0_11_00_00_00));
        tbl.push_back(nop(9'd0));
        tbl.push_back(nop(9'd0));
        // priority, Tuse=1 reader: unready M lw masks the stale add in W
        tbl.push_back(wr(5'd4, 2'd1));
        tbl.push_back(wr(5'd4, 2'd2));
        tbl.push_back(v(5'd4, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 9'b1_00_00_00_00));
        tbl.push_back(v(5'd4, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 9'b0_00_00_00_00));
        tbl.push_back(nop(9'b0_00_00_10_00));
        tbl.push_back(nop(9'd0));
        // store data (Tuse=2) in E: unready M lw masks W add
        tbl.push_back(wr(5'd4, 2'd1));
        tbl.push_back(wr(5'd4, 2'd2));
        tbl.push_back(v(5'd0, 5'd4, 2'd1, 2'd2, 1'b0, 5'd0, 2'd0, 9'd0));
        tbl.push_back(nop(9'd0));
        tbl.push_back(nop(9'd0));
        // two ready writers of $6: M beats W in D, then W feeds E
        tbl.push_back(wr(5'd6, 2'd1));
        tbl.push_back(wr(5'd6, 2'd1));
        tbl.push_back(nop(9'd0));
        tbl.push_back(v(5'd6, 5'd6, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 9'b0_10_10_00_00));
        tbl.push_back(nop(9'b0_00_00_10_10));

        reset = 1'b0;
        drive(nop(9'd0));
        #2 check("reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check("vec", i);
            @(posedge clk);
            #1;
        end

        // reset while a load-use stall is active
        drive(wr(5'd8, 2'd2));
        @(negedge clk);
        check("mid_lw", 0);
        @(posedge clk);
        #1 drive(v(5'd8, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, 2'd0, 9'b1_00_00_00_00));
        @(negedge clk);
        check("mid_stall", 0);
        #1 reset = 1'b0;
        sb.push_back(9'd0);
        #1 check("mid_reset", 0);
        @(posedge clk);
        #1 reset = 1'b1;
        sb.push_back(9'd0);
        @(negedge clk);
        check("post_reset", 0);
        @(posedge clk);
        #1 sb.push_back(9'd0);
        @(negedge clk);
        check("post_reset", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
